// File: rtl/double_to_long.sv
// double_to_long: converts an IEEE-754 binary64 value to a signed 64-bit
// integer, truncating toward zero and saturating on overflow. The mantissa is
// aligned one bit per cycle, so latency depends on the operand's exponent.
module double_to_long #(
    parameter logic [63:0] NAN_VALUE = 64'h8000000000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_a,
    input  logic        in_a_stb,
    output logic        in_a_ack,
    output logic [63:0] out_z,
    output logic        out_z_stb,
    input  logic        out_z_ack
);

    typedef enum logic [2:0] {
        GET    = 3'd0,
        UNPACK = 3'd1,
        SHIFT  = 3'd2,
        PACK   = 3'd3,
        PUT    = 3'd4
    } state_t;

    state_t      state;
    logic [63:0] a;
    logic [63:0] m;
    logic [63:0] result;
    logic        sign;
    logic        special;
    logic        dir_left;
    logic [5:0]  cnt;

    // Field extraction from the latched operand.
    logic               a_sign;
    logic [10:0]        a_exp;
    logic [51:0]        a_frac;
    logic signed [11:0] a_e;
    logic signed [11:0] a_rel;
    logic signed [11:0] a_rel_abs;

    assign a_sign    = a[63];
    assign a_exp     = a[62:52];
    assign a_frac    = a[51:0];
    assign a_e       = $signed({1'b0, a_exp}) - 12'sd1023;
    assign a_rel     = a_e - 12'sd52;
    assign a_rel_abs = (a_rel < 12'sd0) ? -a_rel : a_rel;

    // Largest-magnitude representable result of the given sign.
    function automatic logic [63:0] sat_value(input logic neg);
        sat_value = neg ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
    endfunction

    // Apply the sign to an unsigned magnitude; the magnitude never exceeds
    // 2^63-1 on this path, so the negation cannot overflow.
    function automatic logic [63:0] apply_sign(input logic neg, input logic [63:0] mag);
        apply_sign = neg ? (~mag + 64'd1) : mag;
    endfunction

    // Conversion FSM: handshake, classification, serial alignment, output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GET;
            in_a_ack  <= 1'b0;
            out_z_stb <= 1'b0;
            out_z     <= 64'd0;
            cnt       <= 6'd0;
        end else begin
            case (state)
                GET: begin
                    in_a_ack <= 1'b1;
                    if (in_a_stb && in_a_ack) begin
                        a        <= in_a;
                        in_a_ack <= 1'b0;
                        state    <= UNPACK;
                    end
                end

                UNPACK: begin
                    sign     <= a_sign;
                    m        <= {11'b0, 1'b1, a_frac};
                    dir_left <= (a_e > 12'sd52);
                    cnt      <= a_rel_abs[5:0];
                    special  <= 1'b1;
                    state    <= PACK;
                    if (a_exp == 11'h7FF) begin
                        result <= (a_frac != 52'd0) ? NAN_VALUE : sat_value(a_sign);
                    end else if (a_e < 12'sd0) begin
                        result <= 64'd0;
                    end else if (a_e >= 12'sd63) begin
                        result <= sat_value(a_sign);
                    end else begin
                        special <= 1'b0;
                        if (a_rel_abs != 12'sd0) begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    m   <= dir_left ? {m[62:0], 1'b0} : {1'b0, m[63:1]};
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= PACK;
                    end
                end

                PACK: begin
                    out_z     <= special ? result : apply_sign(sign, m);
                    out_z_stb <= 1'b1;
                    state     <= PUT;
                end

                PUT: begin
                    if (out_z_stb && out_z_ack) begin
                        out_z_stb <= 1'b0;
                        in_a_ack  <= 1'b1;
                        state     <= GET;
                    end
                end

                default: begin
                    state <= GET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_double_to_long.sv
// Directed bench for double_to_long: value, latency, handshake, backpressure
// and mid-conversion reset.
module tb_double_to_long;

    logic        clk;
    logic        rst;
    logic [63:0] in_a;
    logic        in_a_stb;
    logic        in_a_ack;
    logic [63:0] out_z;
    logic        out_z_stb;
    logic        out_z_ack;

    int n_checks = 0;
    int n_fail   = 0;

    double_to_long dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_a_stb  (in_a_stb),
        .in_a_ack  (in_a_ack),
        .out_z     (out_z),
        .out_z_stb (out_z_stb),
        .out_z_ack (out_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, wait for the result, check value and latency.
    // With out_z_ack high the transfer edge is checked too.
    task automatic run(input string tag, input logic [63:0] x,
                       input logic [63:0] expz, input int explat);
        int g;
        int lat;
        g = 0;
        while (!in_a_ack && g < 100) begin
            tick();
            g++;
        end
        check({tag, "_ready"}, {63'd0, in_a_ack}, 64'd1);
        in_a     = x;
        in_a_stb = 1'b1;
        tick();
        in_a_stb = 1'b0;
        check({tag, "_ack_drop"}, {63'd0, in_a_ack}, 64'd0);
        lat = 0;
        while (!out_z_stb && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(explat));
        check({tag, "_z"}, out_z, expz);
        if (out_z_ack) begin
            tick();
            check({tag, "_stb_drop"}, {63'd0, out_z_stb}, 64'd0);
            check({tag, "_ack_back"}, {63'd0, in_a_ack}, 64'd1);
        end
    endtask

    initial begin
        logic [63:0] held;
        rst       = 1'b1;
        in_a      = 64'd0;
        in_a_stb  = 1'b0;
        out_z_ack = 1'b1;
        tick();
        tick();
        check("rst_in_a_ack", {63'd0, in_a_ack}, 64'd0);
        check("rst_out_z_stb", {63'd0, out_z_stb}, 64'd0);
        check("rst_out_z", out_z, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_a_ack", {63'd0, in_a_ack}, 64'd1);

        run("one",      64'h3FF0000000000000, 64'd1,                 54);
        run("m2p75",    64'hC006000000000000, 64'hFFFFFFFFFFFFFFFE, 53);
        run("half",     64'h3FE0000000000000, 64'd0,                 2);
        run("mhalf",    64'hBFE0000000000000, 64'd0,                 2);
        run("negzero",  64'h8000000000000000, 64'd0,                 2);
        run("denorm",   64'h0000000000000001, 64'd0,                 2);
        run("p2_62",    64'h43D0000000000000, 64'h4000000000000000, 12);
        run("p2_52p1",  64'h4330000000000001, 64'h0010000000000001, 2);
        run("e19",      64'h43E158E460913D00, 64'h7FFFFFFFFFFFFFFF, 2);
        run("m2_63",    64'hC3E0000000000000, 64'h8000000000000000, 2);
        run("pinf",     64'h7FF0000000000000, 64'h7FFFFFFFFFFFFFFF, 2);
        run("minf",     64'hFFF0000000000000, 64'h8000000000000000, 2);
        run("nan",      64'h7FF8000000000000, 64'h8000000000000000, 2);

        // Backpressure: 5.0 with the consumer stalled.
        out_z_ack = 1'b0;
        run("bp_five", 64'h4014000000000000, 64'd5, 52);
        held = out_z;
        in_a_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 64'h4000000000000000 + 64'(i);
            tick();
            check("bp_stb_hold", {63'd0, out_z_stb}, 64'd1);
            check("bp_z_hold", out_z, 64'd5);
            check("bp_in_ack_low", {63'd0, in_a_ack}, 64'd0);
        end
        in_a_stb  = 1'b0;
        out_z_ack = 1'b1;
        tick();
        check("bp_stb_drop", {63'd0, out_z_stb}, 64'd0);
        check("bp_in_ack_back", {63'd0, in_a_ack}, 64'd1);
        check("bp_z_after", out_z, held);
        run("bp_next", 64'h4330000000000001, 64'h0010000000000001, 2);

        // Reset in the middle of a 1.0 conversion.
        in_a     = 64'h3FF0000000000000;
        in_a_stb = 1'b1;
        tick();
        in_a_stb = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy", {63'd0, in_a_ack}, 64'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_in_a_ack", {63'd0, in_a_ack}, 64'd0);
        check("mid_rst_stb", {63'd0, out_z_stb}, 64'd0);
        check("mid_rst_z", out_z, 64'd0);
        rst = 1'b0;
        run("three", 64'h4008000000000000, 64'd3, 53);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
